// File: rtl/fetch_seq_ctrl_if.sv
// Handshake and control bundle between the fetch sequencer and the fetch/execute datapath.
interface fetch_seq_ctrl_if;
    logic       imem_req;
    logic       imem_ack;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       ex_done;
    logic       halt_req;
    logic       ex_start;
    logic       PC_en;
    logic       IR_en;
    logic       PC_sel;
    logic       INC_sel;
    logic       halted;
    logic       fault;

    modport master (
        output imem_req, ex_start, PC_en, IR_en, PC_sel, INC_sel, halted, fault,
        input  imem_ack, opcode, branch_taken, ex_done, halt_req
    );

    modport slave (
        input  imem_req, ex_start, PC_en, IR_en, PC_sel, INC_sel, halted, fault,
        output imem_ack, opcode, branch_taken, ex_done, halt_req
    );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle instruction-fetch sequencer: fetch handshake, decode legality check,
// execute start/wait and next-PC source selection, one instruction in flight.
module fetch_seq_ctrl #(
    parameter int unsigned FETCH_TIMEOUT = 255,
    parameter int unsigned BOOT_DELAY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    fetch_seq_ctrl_if.master bus
);
    localparam int unsigned TO_W   = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam int unsigned BOOT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY + 1) : 1;

    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(FETCH_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(FETCH_TIMEOUT - 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              halt_flag;
    logic              ex_first;
    logic [BOOT_W-1:0] boot_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              legal_op;
    logic              timeout_hit;

    always_comb begin
        legal_op = 1'b0;
        case (bus.opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal_op = 1'b1;
            default:                                       legal_op = 1'b0;
        endcase
    end

    // Fires on the last allowed no-ack FETCH cycle; a zero timeout disables it.
    assign timeout_hit = (FETCH_TIMEOUT != 0) && !bus.imem_ack && (to_cnt == TO_LAST);

    // State register; halt_flag marks an IDLE entered from a halted instruction boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            halt_flag <= 1'b0;
            ex_first  <= 1'b0;
        end else begin
            state     <= next_state;
            halt_flag <= (next_state == S_IDLE) && ((state == S_EXEC) || halt_flag);
            ex_first  <= (state == S_DECODE) && (next_state == S_EXEC);
        end
    end

    // Boot delay and fetch-timeout counters; the timeout counter saturates and clears outside FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if ((state == S_IDLE) && !halt_flag && (boot_cnt != BOOT_LAST))
                boot_cnt <= boot_cnt + 1'b1;
            if (state != S_FETCH)
                to_cnt <= '0;
            else if (!bus.imem_ack && (to_cnt != TO_MAX))
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (halt_flag) begin
                    if (!bus.halt_req) next_state = S_FETCH;
                end else if (boot_cnt == BOOT_LAST) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack)   next_state = S_DECODE;
                else if (timeout_hit) next_state = S_FAULT;
            end
            S_DECODE: next_state = legal_op ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (bus.ex_done) next_state = bus.halt_req ? S_IDLE : S_FETCH;
            end
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_FAULT;
        endcase
    end

    // Moore decodes of state, plus the same-cycle load strobes and next-PC selects.
    always_comb begin
        bus.imem_req = (state == S_FETCH);
        bus.ex_start = ex_first;
        bus.halted   = (state == S_IDLE) && halt_flag;
        bus.fault    = (state == S_FAULT);
        bus.IR_en    = (state == S_FETCH) && bus.imem_ack;
        bus.PC_en    = (state == S_EXEC) && bus.ex_done;
        bus.PC_sel   = 1'b0;
        bus.INC_sel  = 1'b0;
        if (bus.PC_en) begin
            case (bus.opcode)
                OP_JAL:    bus.INC_sel = 1'b1;
                OP_JALR:   bus.PC_sel  = 1'b1;
                OP_BRANCH: bus.INC_sel = bus.branch_taken;
                default: begin
                    bus.PC_sel  = 1'b0;
                    bus.INC_sel = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: scenario tasks with a queue of expected next-PC selects.
module tb_fetch_seq_ctrl;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ir_pulses = 0;
    int   pc_pulses = 0;
    logic [1:0] exp_q[$];

    fetch_seq_ctrl_if bus();

    fetch_seq_ctrl #(.FETCH_TIMEOUT(8), .BOOT_DELAY(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (bus.IR_en === 1'b1) ir_pulses++;
        if (bus.PC_en === 1'b1) pc_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {PC_sel, INC_sel} for a completing instruction.
    function automatic logic [1:0] exp_sel(input logic [6:0] op, input logic taken);
        case (op)
            OP_JAL:    return 2'b01;
            OP_JALR:   return 2'b10;
            OP_BRANCH: return {1'b0, taken};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] all_outs();
        return {bus.imem_req, bus.ex_start, bus.PC_en, bus.IR_en,
                bus.PC_sel, bus.INC_sel, bus.halted, bus.fault};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.ex_done = 1'b0; bus.halt_req = 1'b0;
        bus.branch_taken = 1'b0; bus.opcode = 7'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction end to end; starts and ends just after a falling edge.
    task automatic do_instr(input logic [6:0] op, input logic taken, input int ack_wait,
                            input int done_wait, input logic halt, output int lead);
        logic [1:0] want;
        exp_q.push_back(exp_sel(op, taken));
        lead = 0;
        while (bus.imem_req !== 1'b1 && lead < 30) begin
            @(negedge clk);
            lead++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL fetch_start: imem_req=%b, required 1 within 30 cycles", bus.imem_req);
            void'(exp_q.pop_back());
            return;
        end
        bus.halt_req = halt;
        for (int k = 0; k < ack_wait; k++) begin
            bus.imem_ack = 1'b0;
            #1;
            checks++;
            if (bus.IR_en !== 1'b0) begin
                failures++;
                $display("FAIL ir_early: IR_en=%b required 0 (wait %0d)", bus.IR_en, k);
            end
            @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b1) begin
                failures++;
                $display("FAIL req_hold: imem_req=%b required 1 (wait %0d)", bus.imem_req, k);
            end
        end
        bus.imem_ack = 1'b1;
        bus.opcode = op;
        #1;
        checks++;
        if (bus.IR_en !== 1'b1) begin
            failures++;
            $display("FAIL ir_en: IR_en=%b required 1 on ack cycle", bus.IR_en);
        end
        @(negedge clk);
        bus.ex_done = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.ex_start, bus.IR_en, bus.PC_en} !== 4'b0000) begin
            failures++;
            $display("FAIL decode: req/ex_start/IR_en/PC_en=%b required 0000",
                     {bus.imem_req, bus.ex_start, bus.IR_en, bus.PC_en});
        end
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.ex_start !== 1'b1) begin
            failures++;
            $display("FAIL ex_start: ex_start=%b required 1 on EXEC entry", bus.ex_start);
        end
        for (int k = 0; k < done_wait; k++) begin
            bus.ex_done = 1'b0;
            #1;
            checks++;
            if (bus.PC_en !== 1'b0) begin
                failures++;
                $display("FAIL pc_early: PC_en=%b required 0 (wait %0d)", bus.PC_en, k);
            end
            @(negedge clk);
            checks++;
            if (bus.ex_start !== 1'b0) begin
                failures++;
                $display("FAIL ex_start_len: ex_start=%b required 0 after entry", bus.ex_start);
            end
        end
        bus.ex_done = 1'b1;
        bus.branch_taken = taken;
        #1;
        checks++;
        if (bus.PC_en !== 1'b1) begin
            failures++;
            $display("FAIL pc_en: PC_en=%b required 1 on ex_done", bus.PC_en);
        end
        want = exp_q.pop_front();
        checks++;
        if ({bus.PC_sel, bus.INC_sel} !== want) begin
            failures++;
            $display("FAIL sel op=%b taken=%b: PC_sel,INC_sel=%b required %b",
                     op, taken, {bus.PC_sel, bus.INC_sel}, want);
        end
        @(negedge clk);
        bus.ex_done = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        int lead;
        @(negedge clk);
        bus.imem_ack = 1'b1; bus.ex_done = 1'b1; bus.branch_taken = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs: outputs=%b required 00000000", all_outs());
        end
        do_reset();
        do_instr(OP_ADDI, 1'b0, 0, 0, 1'b0, lead);
        checks++;
        if (lead !== 2) begin
            failures++;
            $display("FAIL boot_delay: first imem_req in cycle %0d required 3", lead + 1);
        end
    endtask

    task automatic test_back_to_back();
        int lead;
        int ir0;
        int pc0;
        ir0 = ir_pulses;
        pc0 = pc_pulses;
        for (int i = 0; i < 10; i++) begin
            do_instr(OP_ADDI, 1'b0, 0, 0, 1'b0, lead);
            checks++;
            if (lead !== 0) begin
                failures++;
                $display("FAIL b2b_gap: instr %0d waited %0d extra cycles required 0", i, lead);
            end
        end
        #3;
        checks++;
        if (ir_pulses - ir0 !== 10) begin
            failures++;
            $display("FAIL ir_count: %0d IR_en pulses required 10", ir_pulses - ir0);
        end
        checks++;
        if (pc_pulses - pc0 !== 10) begin
            failures++;
            $display("FAIL pc_count: %0d PC_en pulses required 10", pc_pulses - pc0);
        end
    endtask

    task automatic test_next_pc();
        int lead;
        do_instr(OP_BRANCH, 1'b1, 1, 0, 1'b0, lead);
        do_instr(OP_BRANCH, 1'b0, 0, 0, 1'b0, lead);
        do_instr(OP_JAL,    1'b0, 0, 0, 1'b0, lead);
        do_instr(OP_JALR,   1'b1, 2, 0, 1'b0, lead);
        do_instr(OP_LOAD,   1'b1, 0, 1, 1'b0, lead);
        do_instr(OP_JAL,    1'b0, 0, 4, 1'b0, lead);
        do_instr(OP_BRANCH, 1'b1, 3, 4, 1'b0, lead);
    endtask

    task automatic test_halt();
        int lead;
        do_instr(OP_ADDI, 1'b0, 1, 2, 1'b1, lead);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.halted, bus.imem_req} !== 2'b10) begin
                failures++;
                $display("FAIL halted: halted,imem_req=%b required 10 (cycle %0d)",
                         {bus.halted, bus.imem_req}, k);
            end
            @(negedge clk);
        end
        bus.halt_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.halted, bus.imem_req} !== 2'b01) begin
            failures++;
            $display("FAIL halt_release: halted,imem_req=%b required 01",
                     {bus.halted, bus.imem_req});
        end
        do_instr(OP_JALR, 1'b0, 0, 0, 1'b0, lead);
    endtask

    task automatic test_rst_async();
        int lead;
        lead = 0;
        while (bus.imem_req !== 1'b1 && lead < 30) begin
            @(negedge clk);
            lead++;
        end
        bus.imem_ack = 1'b1;
        bus.opcode = OP_ADDI;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        bus.ex_done = 1'b1;
        #1;
        checks++;
        if ({bus.ex_start, bus.PC_en} !== 2'b11) begin
            failures++;
            $display("FAIL exec_pre_rst: ex_start,PC_en=%b required 11", {bus.ex_start, bus.PC_en});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 8'h00) begin
            failures++;
            $display("FAIL rst_exec: outputs=%b required 00000000", all_outs());
        end
        @(negedge clk);
        bus.ex_done = 1'b0;
        rst = 1'b0;
        do_instr(OP_ADDI, 1'b0, 0, 0, 1'b0, lead);
        checks++;
        if (lead !== 2) begin
            failures++;
            $display("FAIL rst_reboot: first imem_req in cycle %0d required 3", lead + 1);
        end
        #1;
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_fetch: imem_req=%b required 1", bus.imem_req);
        end
        bus.imem_ack = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.IR_en} !== 2'b00) begin
            failures++;
            $display("FAIL rst_fetch: imem_req,IR_en=%b required 00", {bus.imem_req, bus.IR_en});
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int lead;
        do_instr(OP_ADDI, 1'b0, 6, 0, 1'b0, lead);
        do_instr(OP_ADDI, 1'b0, 7, 0, 1'b0, lead);
        checks++;
        if (bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: fault=%b required 0", bus.fault);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({bus.imem_req, bus.fault} !== 2'b10) begin
                failures++;
                $display("FAIL to_wait: imem_req,fault=%b required 10 (cycle %0d)",
                         {bus.imem_req, bus.fault}, k + 1);
            end
            bus.imem_ack = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            bus.imem_ack = 1'b1;
            #1;
            checks++;
            if ({bus.imem_req, bus.fault, bus.IR_en} !== 3'b010) begin
                failures++;
                $display("FAIL to_fault: imem_req,fault,IR_en=%b required 010",
                         {bus.imem_req, bus.fault, bus.IR_en});
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        int lead;
        lead = 0;
        while (bus.imem_req !== 1'b1 && lead < 30) begin
            @(negedge clk);
            lead++;
        end
        bus.imem_ack = 1'b1;
        bus.opcode = 7'b0000000;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL ill_decode: fault=%b required 0 in DECODE", bus.fault);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.ex_done = 1'b1;
            bus.imem_ack = 1'b1;
            #1;
            checks++;
            if (all_outs() !== 8'b0000_0001) begin
                failures++;
                $display("FAIL ill_fault: outputs=%b required 00000001 (cycle %0d)", all_outs(), k);
            end
        end
        do_reset();
        #1;
        checks++;
        if (all_outs() !== 8'h00) begin
            failures++;
            $display("FAIL fault_clear: outputs=%b required 00000000", all_outs());
        end
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.ex_done = 1'b0; bus.halt_req = 1'b0;
        bus.branch_taken = 1'b0; bus.opcode = 7'd0;
        test_reset();
        test_back_to_back();
        test_next_pc();
        test_halt();
        test_rst_async();
        test_timeout();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
